axil2emif: RTL and testbench
============================

// Module: axil2emif
// PURPOSE
//  AXI-Lite slave to EMIF (async SRAM-style) master bridge: the outbound companion of the EMIF-to-AXI-Lite path.
//  Each accepted AXI-Lite read or write becomes exactly one 32-bit EMIF bus cycle with parameterised setup/strobe/hold timing.
//  Sits between an on-chip AXI-Lite interconnect and external EMIF pins; tri-state IOBUFs live in the top-level wrapper.
// PARAMETERS
//  AXIL_ADDR_BASE   32'h0000_0000  byte base of the AXI-Lite window
//  AXIL_ADDR_WIDTH  16             window size 2^W bytes (max 26)
//  EMIF_ADDR_BASE   24'h000000     EMIF word address for window offset 0
//  SETUP            1              eclk cycles nce low before strobe (>=1)
//  STROBE           4              eclk cycles noe/nwe low (>=1)
//  HOLD             1              eclk cycles nce low after strobe (>=1)
//  TURNAROUND       1              idle cycles, nce high, after a read before the next cycle (>=1)
// PORTS
//  eclk             in   1   clock; AXI-Lite and EMIF both run on eclk
//  nrst             in   1   reset, asynchronous, active-low
//  s_axil_awvalid/awready  in/out 1; s_axil_awaddr in 32; s_axil_awprot in 3 (ignored)
//  s_axil_wvalid/wready    in/out 1; s_axil_wdata in 32; s_axil_wstrb in 4
//  s_axil_bvalid/bready    out/in 1; s_axil_bresp out 2
//  s_axil_arvalid/arready  in/out 1; s_axil_araddr in 32; s_axil_arprot in 3 (ignored)
//  s_axil_rvalid/rready    out/in 1; s_axil_rdata out 32; s_axil_rresp out 2
//  emif_nce/noe/nwe out  1   EMIF strobes, active-low
//  emif_addr        out  24  EMIF word address
//  emif_data_o      out  32  write data to IOBUF I
//  emif_data_oe     out  1   1 = drive pins (wrapper inverts for IOBUF T)
//  emif_data_i      in   32  read data from IOBUF O
//  busy             out  1   any transaction captured, in flight or response pending
// BEHAVIOUR
//  Reset (async): nce/noe/nwe=1, emif_data_oe=0, emif_addr=0, emif_data_o=0, all *ready/*valid=0, resp=OKAY, rdata=0, busy=0.
//  Capture: AW and W registered independently; awready=!aw_held, wready=!w_held, arready=!ar_held, all 0 while in reset.
//  Arbitration in IDLE: write eligible when aw_held&w_held, read when ar_held; both -> grant opposite of last grant (reset: write first).
//  No new grant while bvalid or rvalid is pending (single outstanding transaction).
//  Decode: off=addr-AXIL_ADDR_BASE; in-window iff addr>=BASE && off<2^W; emif_addr=EMIF_ADDR_BASE+off[W-1:2] (mod 2^24).
//  Error: out-of-window, or write with wstrb!=4'hF -> no EMIF cycle, resp SLVERR(2'b10), rdata=0, response 1 cycle after grant.
//  FSM: IDLE -> SETUP(SETUP cyc) -> STROBE(STROBE cyc) -> HOLD(HOLD cyc) -> RESP -> [read: TURN(TURNAROUND cyc)] -> IDLE.
//  SETUP/STROBE/HOLD: nce=0, emif_addr stable; STROBE: noe=0 (read) or nwe=0 (write); all outputs registered, glitch-free.
//  Write: emif_data_oe=1 and emif_data_o stable SETUP..HOLD inclusive; oe=0 and data_o=0 otherwise.
//  Read: emif_data_i sampled on last STROBE cycle into rdata; emif_data_oe stays 0.
//  RESP: bvalid/rvalid asserted, held with stable data until ready; resp OKAY(2'b00); held regs cleared on grant.
//  Latency (defaults, no backpressure): grant -> bvalid = SETUP+STROBE+HOLD+1 = 7 eclk after grant.
//  Counter: single down-counter, width $clog2(max(SETUP,STROBE,HOLD,TURNAROUND)+1), reloaded on each state entry.
//  Reset mid-cycle: strobes deassert immediately (async), transaction dropped, no response issued.
// STRUCTURE
//  Package emif_axil_pkg: FSM state encoding, AXI resp codes (OKAY/SLVERR), shared with the inbound bridge.
//  One sub-module: emif_cycle_timer (load value, load strobe, done flag) used for all phase counts.
// TESTING
//  Write 0x0000_0010=0xDEADBEEF, defaults -> emif_addr=0x000004, nwe low exactly 4 cycles, nce low 6, oe 6, bresp=OKAY.
//  Read 0x0000_0020, emif_data_i=0x12345678 -> noe low 4 cycles, rdata=0x12345678, then nce high >=1 cycle before next.
//  AW and AR both held together, twice -> grants write,read,write,read; no overlap of nce cycles.
//  awaddr=0x0001_0000 (W=16), or wstrb=4'h3 -> nce never falls, bresp=SLVERR one cycle after grant.
//  bready held low 10 cycles -> bvalid/bresp stable, no new EMIF cycle starts, busy=1 throughout.
//  nrst asserted during STROBE -> nce/nwe/noe=1 and oe=0 same cycle; after release no stale response.

Source files
------------

// File: rtl/emif_axil_pkg.sv
// ============================================================================
//  Module      : emif_axil_pkg
//  Description : Shared FSM encoding and AXI response codes for the EMIF
//                <-> AXI-Lite bridges.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package emif_axil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RESP   = 3'd4,
        ST_TURN   = 3'd5
    } emif_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

`default_nettype wire

// File: rtl/emif_cycle_timer.sv
// ============================================================================
//  Module      : emif_cycle_timer
//  Description : Loadable down-counter that flags when a phase has elapsed.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module emif_cycle_timer #(
    parameter int CW = 3
) (
    input  logic          eclk,
    input  logic          nrst,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    output logic          o_done
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge eclk or negedge nrst) begin
        if (!nrst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/axil2emif.sv
// ============================================================================
//  Module      : axil2emif
//  Description : AXI-Lite slave to EMIF async-SRAM master; one 32-bit bus
//                cycle per accepted transaction.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module axil2emif
    import emif_axil_pkg::*;
#(
    parameter logic [31:0] AXIL_ADDR_BASE  = 32'h0000_0000,
    parameter int          AXIL_ADDR_WIDTH = 16,
    parameter logic [23:0] EMIF_ADDR_BASE  = 24'h000000,
    parameter int          SETUP           = 1,
    parameter int          STROBE          = 4,
    parameter int          HOLD            = 1,
    parameter int          TURNAROUND      = 1
) (
    input  logic        eclk,
    input  logic        nrst,
    input  logic        s_axil_awvalid,
    output logic        s_axil_awready,
    input  logic [31:0] s_axil_awaddr,
    input  logic [2:0]  s_axil_awprot,
    input  logic        s_axil_wvalid,
    output logic        s_axil_wready,
    input  logic [31:0] s_axil_wdata,
    input  logic [3:0]  s_axil_wstrb,
    output logic        s_axil_bvalid,
    input  logic        s_axil_bready,
    output logic [1:0]  s_axil_bresp,
    input  logic        s_axil_arvalid,
    output logic        s_axil_arready,
    input  logic [31:0] s_axil_araddr,
    input  logic [2:0]  s_axil_arprot,
    output logic        s_axil_rvalid,
    input  logic        s_axil_rready,
    output logic [31:0] s_axil_rdata,
    output logic [1:0]  s_axil_rresp,
    output logic        emif_nce,
    output logic        emif_noe,
    output logic        emif_nwe,
    output logic [23:0] emif_addr,
    output logic [31:0] emif_data_o,
    output logic        emif_data_oe,
    input  logic [31:0] emif_data_i,
    output logic        busy
);

    localparam int c_MAX_A = (SETUP > STROBE) ? SETUP : STROBE;
    localparam int c_MAX_B = (HOLD > TURNAROUND) ? HOLD : TURNAROUND;
    localparam int c_MAX_D = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int c_CW    = $clog2(c_MAX_D + 1);

    emif_state_t r_state, w_next;

    logic        r_live;
    logic        r_aw_held, r_w_held, r_ar_held;
    logic [31:0] r_awaddr, r_araddr, r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_last_wr, r_is_wr;
    logic        r_bvalid, r_rvalid;
    logic [1:0]  r_bresp, r_rresp;
    logic [31:0] r_rdata;
    logic        r_nce, r_noe, r_nwe, r_oe;
    logic [23:0] r_emif_addr;
    logic [31:0] r_data_o;

    logic              w_grant_wr, w_grant_rd;
    logic              w_load, w_done;
    logic [c_CW-1:0]   w_load_val;
    logic              w_act_next, w_wr_next;
    logic [31:0]       w_aw_off, w_ar_off;
    logic              w_aw_in, w_ar_in, w_wr_err, w_rd_err;
    logic [23:0]       w_aw_eaddr, w_ar_eaddr;
    logic              w_unused;

    // Window decode: offset must be non-negative and below 2^AXIL_ADDR_WIDTH
    assign w_aw_off   = r_awaddr - AXIL_ADDR_BASE;
    assign w_ar_off   = r_araddr - AXIL_ADDR_BASE;
    assign w_aw_in    = (r_awaddr >= AXIL_ADDR_BASE) && (w_aw_off[31:AXIL_ADDR_WIDTH] == '0);
    assign w_ar_in    = (r_araddr >= AXIL_ADDR_BASE) && (w_ar_off[31:AXIL_ADDR_WIDTH] == '0);
    assign w_aw_eaddr = EMIF_ADDR_BASE + 24'(w_aw_off[AXIL_ADDR_WIDTH-1:2]);
    assign w_ar_eaddr = EMIF_ADDR_BASE + 24'(w_ar_off[AXIL_ADDR_WIDTH-1:2]);
    assign w_wr_err   = !w_aw_in || (r_wstrb != 4'hF);
    assign w_rd_err   = !w_ar_in;
    assign w_unused   = ^{s_axil_awprot, s_axil_arprot, w_aw_off[1:0], w_ar_off[1:0]};

    emif_cycle_timer #(.CW(c_CW)) u_timer (
        .eclk       (eclk),
        .nrst       (nrst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_done)
    );

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        w_grant_wr = 1'b0;
        w_grant_rd = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!r_bvalid && !r_rvalid) begin
                    if (r_aw_held && r_w_held && (!r_ar_held || !r_last_wr)) begin
                        w_grant_wr = 1'b1;
                    end else if (r_ar_held) begin
                        w_grant_rd = 1'b1;
                    end
                end
                if ((w_grant_wr && w_wr_err) || (w_grant_rd && w_rd_err)) begin
                    w_next = ST_RESP;
                end else if (w_grant_wr || w_grant_rd) begin
                    w_next     = ST_SETUP;
                    w_load     = 1'b1;
                    w_load_val = c_CW'(SETUP - 1);
                end
            end
            ST_SETUP: begin
                if (w_done) begin
                    w_next     = ST_STROBE;
                    w_load     = 1'b1;
                    w_load_val = c_CW'(STROBE - 1);
                end
            end
            ST_STROBE: begin
                if (w_done) begin
                    w_next     = ST_HOLD;
                    w_load     = 1'b1;
                    w_load_val = c_CW'(HOLD - 1);
                end
            end
            ST_HOLD: begin
                if (w_done) w_next = ST_RESP;
            end
            ST_RESP: begin
                if (r_is_wr && r_bvalid && s_axil_bready) begin
                    w_next = ST_IDLE;
                end else if (!r_is_wr && r_rvalid && s_axil_rready) begin
                    w_next     = ST_TURN;
                    w_load     = 1'b1;
                    w_load_val = c_CW'(TURNAROUND - 1);
                end
            end
            ST_TURN: begin
                if (w_done) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // EMIF pins are registered from the next state so they change only on clock edges
    assign w_act_next = (w_next == ST_SETUP) || (w_next == ST_STROBE) || (w_next == ST_HOLD);
    assign w_wr_next  = w_grant_wr || ((r_state != ST_IDLE) && r_is_wr);

    always_ff @(posedge eclk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= ST_IDLE;
            r_live      <= 1'b0;
            r_aw_held   <= 1'b0;
            r_w_held    <= 1'b0;
            r_ar_held   <= 1'b0;
            r_awaddr    <= '0;
            r_araddr    <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_last_wr   <= 1'b0;
            r_is_wr     <= 1'b0;
            r_bvalid    <= 1'b0;
            r_rvalid    <= 1'b0;
            r_bresp     <= RESP_OKAY;
            r_rresp     <= RESP_OKAY;
            r_rdata     <= '0;
            r_nce       <= 1'b1;
            r_noe       <= 1'b1;
            r_nwe       <= 1'b1;
            r_oe        <= 1'b0;
            r_emif_addr <= '0;
            r_data_o    <= '0;
        end else begin
            r_live  <= 1'b1;
            r_state <= w_next;

            if (s_axil_awvalid && s_axil_awready) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= s_axil_awaddr;
            end
            if (s_axil_wvalid && s_axil_wready) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_axil_wdata;
                r_wstrb  <= s_axil_wstrb;
            end
            if (s_axil_arvalid && s_axil_arready) begin
                r_ar_held <= 1'b1;
                r_araddr  <= s_axil_araddr;
            end

            if (w_grant_wr) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_last_wr <= 1'b1;
                r_is_wr   <= 1'b1;
                if (w_wr_err) begin
                    r_bvalid <= 1'b1;
                    r_bresp  <= RESP_SLVERR;
                end else begin
                    r_emif_addr <= w_aw_eaddr;
                end
            end
            if (w_grant_rd) begin
                r_ar_held <= 1'b0;
                r_last_wr <= 1'b0;
                r_is_wr   <= 1'b0;
                if (w_rd_err) begin
                    r_rvalid <= 1'b1;
                    r_rresp  <= RESP_SLVERR;
                    r_rdata  <= '0;
                end else begin
                    r_emif_addr <= w_ar_eaddr;
                end
            end

            if ((r_state == ST_STROBE) && w_done && !r_is_wr) r_rdata <= emif_data_i;
            if ((r_state == ST_HOLD) && w_done) begin
                if (r_is_wr) begin
                    r_bvalid <= 1'b1;
                    r_bresp  <= RESP_OKAY;
                end else begin
                    r_rvalid <= 1'b1;
                    r_rresp  <= RESP_OKAY;
                end
            end
            if (r_bvalid && s_axil_bready) r_bvalid <= 1'b0;
            if (r_rvalid && s_axil_rready) r_rvalid <= 1'b0;

            r_nce    <= !w_act_next;
            r_noe    <= !((w_next == ST_STROBE) && !r_is_wr);
            r_nwe    <= !((w_next == ST_STROBE) && r_is_wr);
            r_oe     <= w_act_next && w_wr_next;
            r_data_o <= (w_act_next && w_wr_next) ? (w_grant_wr ? r_wdata : r_data_o) : '0;
        end
    end

    assign s_axil_awready = r_live && !r_aw_held;
    assign s_axil_wready  = r_live && !r_w_held;
    assign s_axil_arready = r_live && !r_ar_held;
    assign s_axil_bvalid  = r_bvalid;
    assign s_axil_bresp   = r_bresp;
    assign s_axil_rvalid  = r_rvalid;
    assign s_axil_rresp   = r_rresp;
    assign s_axil_rdata   = r_rdata;
    assign emif_nce       = r_nce;
    assign emif_noe       = r_noe;
    assign emif_nwe       = r_nwe;
    assign emif_addr      = r_emif_addr;
    assign emif_data_o    = r_data_o;
    assign emif_data_oe   = r_oe;
    assign busy           = r_aw_held || r_w_held || r_ar_held || (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_axil2emif.sv
// ============================================================================
//  Module      : tb_axil2emif
//  Description : Directed self-checking bench for the AXI-Lite to EMIF bridge.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_axil2emif;

    logic        eclk = 1'b0;
    logic        nrst;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        nce, noe, nwe, oe, busy;
    logic [23:0] eaddr;
    logic [31:0] edata_o, edata_i;

    int n_tests = 0;
    int n_fail  = 0;

    axil2emif dut (
        .eclk(eclk), .nrst(nrst),
        .s_axil_awvalid(awvalid), .s_axil_awready(awready), .s_axil_awaddr(awaddr), .s_axil_awprot(3'b000),
        .s_axil_wvalid(wvalid), .s_axil_wready(wready), .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
        .s_axil_bvalid(bvalid), .s_axil_bready(bready), .s_axil_bresp(bresp),
        .s_axil_arvalid(arvalid), .s_axil_arready(arready), .s_axil_araddr(araddr), .s_axil_arprot(3'b000),
        .s_axil_rvalid(rvalid), .s_axil_rready(rready), .s_axil_rdata(rdata), .s_axil_rresp(rresp),
        .emif_nce(nce), .emif_noe(noe), .emif_nwe(nwe), .emif_addr(eaddr),
        .emif_data_o(edata_o), .emif_data_oe(oe), .emif_data_i(edata_i), .busy(busy)
    );

    always #5 eclk = ~eclk;

    // Bus monitor sampled mid-cycle
    int          mon_nce, mon_noe, mon_nwe, mon_oe, gap, min_gap;
    logic        prev_nce = 1'b1, prev_noe = 1'b1, prev_nwe = 1'b1;
    logic [23:0] wr_addr, rd_addr;
    logic [31:0] wr_data;
    bit          log_q[$];

    always @(negedge eclk) begin
        if (!nce) mon_nce++;
        if (!noe) mon_noe++;
        if (!nwe) mon_nwe++;
        if (oe)   mon_oe++;
        if (!nwe && prev_nwe) begin
            log_q.push_back(1'b1);
            wr_addr = eaddr;
            wr_data = edata_o;
        end
        if (!noe && prev_noe) begin
            log_q.push_back(1'b0);
            rd_addr = eaddr;
        end
        if (nce) gap++;
        else if (prev_nce) begin
            if (gap < min_gap) min_gap = gap;
            gap = 0;
        end
        prev_nce = nce;
        prev_noe = noe;
        prev_nwe = nwe;
    end

    task automatic step();
        @(posedge eclk);
        #1;
    endtask

    task automatic clear_mon();
        mon_nce = 0; mon_noe = 0; mon_nwe = 0; mon_oe = 0;
        gap = 0; min_gap = 1000;
        log_q.delete();
    endtask

    task automatic send_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 50 && (awvalid || wvalid); i++) begin
            automatic logic ad = awvalid && awready;
            automatic logic wd = wvalid && wready;
            step();
            if (ad) awvalid = 1'b0;
            if (wd) wvalid  = 1'b0;
        end
        n_tests++;
        if (awvalid || wvalid) begin
            n_fail++;
            $display("FAIL write_handshake: aw=%0b w=%0b still pending, required both accepted", awvalid, wvalid);
            awvalid = 1'b0; wvalid = 1'b0;
        end
    endtask

    task automatic send_read(input logic [31:0] a);
        araddr = a; arvalid = 1'b1;
        for (int i = 0; i < 50 && arvalid; i++) begin
            automatic logic ad = arvalid && arready;
            step();
            if (ad) arvalid = 1'b0;
        end
        n_tests++;
        if (arvalid) begin
            n_fail++;
            $display("FAIL read_handshake: ar still pending, required accepted");
            arvalid = 1'b0;
        end
    endtask

    task automatic wait_b(output int n);
        n = 0;
        while (!bvalid && n < 100) begin step(); n++; end
    endtask

    task automatic wait_r(output int n);
        n = 0;
        while (!rvalid && n < 100) begin step(); n++; end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
        awaddr = 0; wdata = 0; wstrb = 0; araddr = 0; edata_i = 32'h1234_5678;
        repeat (3) step();
        n_tests++;
        if ({nce, noe, nwe, oe} !== 4'b1110) begin n_fail++; $display("FAIL reset_strobes: got %b required 1110", {nce, noe, nwe, oe}); end
        n_tests++;
        if ({eaddr, edata_o} !== 56'h0) begin n_fail++; $display("FAIL reset_bus: addr=%h data=%h required 0", eaddr, edata_o); end
        n_tests++;
        if ({awready, wready, arready, bvalid, rvalid, busy} !== 6'b0) begin
            n_fail++; $display("FAIL reset_handshake: got %b required 000000", {awready, wready, arready, bvalid, rvalid, busy});
        end
        n_tests++;
        if ({bresp, rresp, rdata} !== 36'h0) begin n_fail++; $display("FAIL reset_resp: bresp=%b rresp=%b rdata=%h required 0", bresp, rresp, rdata); end
        #2 nrst = 1'b1;
        step();
        n_tests++;
        if ({awready, wready, arready} !== 3'b111) begin n_fail++; $display("FAIL ready_after_reset: got %b required 111", {awready, wready, arready}); end
    endtask

    task automatic test_write();
        int n;
        clear_mon();
        send_write(32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        wait_b(n);
        n_tests++;
        if (n !== 7) begin n_fail++; $display("FAIL write_latency: got %0d required 7", n); end
        n_tests++;
        if (bresp !== 2'b00) begin n_fail++; $display("FAIL write_bresp: got %b required 00", bresp); end
        n_tests++;
        if ({mon_nwe, mon_nce, mon_oe, mon_noe} !== {32'd4, 32'd6, 32'd6, 32'd0}) begin
            n_fail++; $display("FAIL write_timing: nwe=%0d nce=%0d oe=%0d noe=%0d required 4 6 6 0", mon_nwe, mon_nce, mon_oe, mon_noe);
        end
        n_tests++;
        if ({wr_addr, wr_data} !== {24'h000004, 32'hDEAD_BEEF}) begin
            n_fail++; $display("FAIL write_bus: addr=%h data=%h required 000004 deadbeef", wr_addr, wr_data);
        end
        step();
        n_tests++;
        if ({bvalid, oe, edata_o} !== 34'h0) begin n_fail++; $display("FAIL write_release: bvalid=%b oe=%b data=%h required 0", bvalid, oe, edata_o); end
    endtask

    task automatic test_read();
        int n;
        clear_mon();
        edata_i = 32'h1234_5678;
        send_read(32'h0000_0020);
        wait_r(n);
        n_tests++;
        if (n !== 7) begin n_fail++; $display("FAIL read_latency: got %0d required 7", n); end
        n_tests++;
        if ({rdata, rresp} !== {32'h1234_5678, 2'b00}) begin n_fail++; $display("FAIL read_data: rdata=%h rresp=%b required 12345678 00", rdata, rresp); end
        n_tests++;
        if ({mon_noe, mon_nce, mon_nwe, mon_oe} !== {32'd4, 32'd6, 32'd0, 32'd0}) begin
            n_fail++; $display("FAIL read_timing: noe=%0d nce=%0d nwe=%0d oe=%0d required 4 6 0 0", mon_noe, mon_nce, mon_nwe, mon_oe);
        end
        n_tests++;
        if (rd_addr !== 24'h000008) begin n_fail++; $display("FAIL read_addr: got %h required 000008", rd_addr); end
        step();
        n_tests++;
        if (rvalid !== 1'b0) begin n_fail++; $display("FAIL read_release: rvalid=%b required 0", rvalid); end
    endtask

    task automatic test_arbitration();
        clear_mon();
        for (int r = 0; r < 2; r++) begin
            awaddr = 32'h30; wdata = 32'h0BAD_F00D; wstrb = 4'hF; araddr = 32'h40;
            awvalid = 1; wvalid = 1; arvalid = 1;
            for (int i = 0; i < 50 && (awvalid || wvalid || arvalid); i++) begin
                automatic logic ad = awvalid && awready;
                automatic logic wd = wvalid && wready;
                automatic logic rd = arvalid && arready;
                step();
                if (ad) awvalid = 0;
                if (wd) wvalid = 0;
                if (rd) arvalid = 0;
            end
            for (int i = 0; i < 200 && busy; i++) step();
        end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL arb_drain: busy=%b required 0", busy); end
        n_tests++;
        if (log_q.size() !== 4) begin
            n_fail++; $display("FAIL arb_count: got %0d cycles required 4", log_q.size());
        end else if ({log_q[0], log_q[1], log_q[2], log_q[3]} !== 4'b1010) begin
            n_fail++; $display("FAIL arb_order: got %b required 1010 (1=write)", {log_q[0], log_q[1], log_q[2], log_q[3]});
        end
        n_tests++;
        if (min_gap < 1 || mon_nce !== 24) begin n_fail++; $display("FAIL arb_gap: min_gap=%0d nce=%0d required >=1 and 24", min_gap, mon_nce); end
    endtask

    task automatic test_errors();
        int n;
        clear_mon();
        send_write(32'h0001_0000, 32'h1111_1111, 4'hF);
        wait_b(n);
        n_tests++;
        if ({n, bresp} !== {32'd1, 2'b10}) begin n_fail++; $display("FAIL err_window: latency=%0d bresp=%b required 1 10", n, bresp); end
        step();
        send_write(32'h0000_0010, 32'h2222_2222, 4'h3);
        wait_b(n);
        n_tests++;
        if ({n, bresp} !== {32'd1, 2'b10}) begin n_fail++; $display("FAIL err_wstrb: latency=%0d bresp=%b required 1 10", n, bresp); end
        step();
        send_read(32'h0002_0000);
        wait_r(n);
        n_tests++;
        if ({n, rresp, rdata} !== {32'd1, 2'b10, 32'h0}) begin
            n_fail++; $display("FAIL err_read: latency=%0d rresp=%b rdata=%h required 1 10 0", n, rresp, rdata);
        end
        repeat (3) step();
        n_tests++;
        if (mon_nce !== 0) begin n_fail++; $display("FAIL err_no_cycle: nce low %0d cycles required 0", mon_nce); end
    endtask

    task automatic test_backpressure();
        int n, bad, nce_before;
        clear_mon();
        bready = 0;
        send_write(32'h0000_0050, 32'hA5A5_5A5A, 4'hF);
        wait_b(n);
        send_read(32'h0000_0060);
        nce_before = mon_nce;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (bvalid !== 1'b1 || bresp !== 2'b00 || busy !== 1'b1) bad++;
            step();
        end
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL bp_stable: %0d bad cycles required 0", bad); end
        n_tests++;
        if (mon_nce !== nce_before || nce_before !== 6) begin
            n_fail++; $display("FAIL bp_no_cycle: nce before=%0d after=%0d required 6 6", nce_before, mon_nce);
        end
        bready = 1;
        step();
        n_tests++;
        if (bvalid !== 1'b0) begin n_fail++; $display("FAIL bp_release: bvalid=%b required 0", bvalid); end
        wait_r(n);
        step();
        n_tests++;
        if ({mon_noe, rd_addr} !== {32'd4, 24'h000018}) begin n_fail++; $display("FAIL bp_read: noe=%0d addr=%h required 4 000018", mon_noe, rd_addr); end
        repeat (3) step();
    endtask

    task automatic test_reset_mid();
        int stale;
        clear_mon();
        send_write(32'h0000_0070, 32'h5555_AAAA, 4'hF);
        for (int i = 0; i < 20 && nwe; i++) step();
        step();
        #2 nrst = 1'b0;
        #1;
        n_tests++;
        if ({nce, nwe, noe, oe, busy} !== 5'b11100) begin
            n_fail++; $display("FAIL mid_reset: nce/nwe/noe/oe/busy=%b required 11100", {nce, nwe, noe, oe, busy});
        end
        @(posedge eclk);
        #3 nrst = 1'b1;
        stale = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (bvalid || rvalid || !nce) stale++;
        end
        n_tests++;
        if (stale !== 0) begin n_fail++; $display("FAIL mid_reset_stale: %0d cycles with activity required 0", stale); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_arbitration();
        test_errors();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
